// File: rtl/keymatrix_pkg.sv
// rtl/keymatrix_pkg.sv - key index constants and ASCII-to-matrix decode
// Purpose: shared constants, the decode result struct and ascii_to_key().
// Ports: none (package).
package keymatrix_pkg;

  localparam int KEY_SHIFT = 53;
  localparam int KEY_ENTER = 48;
  localparam int KEY_BREAK = 49;
  localparam int KEY_LEFT  = 29;
  localparam int KEY_SPACE = 31;

  typedef struct packed {
    logic       valid;
    logic [5:0] key;
    logic       shift;
  } key_code_t;

  function automatic key_code_t mk_code(input int key, input logic shift);
    key_code_t r;
    r.valid = 1'b1;
    r.key   = 6'(key);
    r.shift = shift;
    return r;
  endfunction

  function automatic key_code_t ascii_to_key(input logic [7:0] ch);
    key_code_t r;
    r.valid = 1'b0;
    r.key   = 6'd0;
    r.shift = 1'b0;
    if (ch >= 8'h41 && ch <= 8'h5A) begin
      r = mk_code(int'(ch) - 'h40, 1'b0);
    end else if (ch >= 8'h61 && ch <= 8'h7A) begin
      r = mk_code(int'(ch) - 'h60, 1'b0);
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      r = mk_code(int'(ch) - 'h30 + 32, 1'b0);
    end else begin
      case (ch)
        8'h0D, 8'h0A: r = mk_code(KEY_ENTER, 1'b0);
        8'h08, 8'h7F: r = mk_code(KEY_LEFT, 1'b0);
        8'h1B:        r = mk_code(KEY_BREAK, 1'b0);
        8'h20:        r = mk_code(KEY_SPACE, 1'b0);
        // shifted digit row
        8'h5F:        r = mk_code(32, 1'b1);
        8'h21:        r = mk_code(33, 1'b1);
        8'h22:        r = mk_code(34, 1'b1);
        8'h23:        r = mk_code(35, 1'b1);
        8'h24:        r = mk_code(36, 1'b1);
        8'h25:        r = mk_code(37, 1'b1);
        8'h26:        r = mk_code(38, 1'b1);
        8'h5C:        r = mk_code(39, 1'b1);
        8'h28:        r = mk_code(40, 1'b1);
        8'h29:        r = mk_code(41, 1'b1);
        8'h2B:        r = mk_code(42, 1'b1);
        8'h2A:        r = mk_code(43, 1'b1);
        8'h3C:        r = mk_code(44, 1'b1);
        8'h2D:        r = mk_code(45, 1'b1);
        8'h3E:        r = mk_code(46, 1'b1);
        8'h3F:        r = mk_code(47, 1'b1);
        // punctuation keys, unshifted
        8'h3B:        r = mk_code(42, 1'b0);
        8'h3A:        r = mk_code(43, 1'b0);
        8'h2C:        r = mk_code(44, 1'b0);
        8'h3D:        r = mk_code(45, 1'b0);
        8'h2E:        r = mk_code(46, 1'b0);
        8'h2F:        r = mk_code(47, 1'b0);
        default:      r.valid = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_key_matrix_if.sv
// rtl/uart_key_matrix_if.sv - receive stream and CPU keyboard read bus
// Purpose: bundles the UART byte strobe and the CPU keyboard-window read port.
// Ports: rx_data/rx_valid (byte in), key_rd/key_addr (read request), key_out (read data).
interface uart_key_matrix_if #(
  parameter int KEY_W = 6
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             key_rd;
  logic [KEY_W-1:0] key_addr;
  logic [7:0]       key_out;

  modport master (output rx_data, rx_valid, key_rd, key_addr, input key_out);
  modport slave  (input rx_data, rx_valid, key_rd, key_addr, output key_out);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// Purpose: byte buffer between the UART and the key replay FSM.
// Ports: clk, reset (async high), clear (sync empty), push/wdata, pop/rdata (show-ahead), full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_key_matrix.sv
// rtl/uart_key_matrix.sv - replays received characters as timed keyboard matrix presses
// Purpose: buffers UART bytes and presses/releases one matrix key (plus SHIFT) per byte.
// Ports: clk, reset (async high), bus (rx stream + CPU read), flush, aux_n,
//        busy, overflow (sticky), dropped (pulse per unmapped byte).
module uart_key_matrix
  import keymatrix_pkg::*;
#(
  parameter int N_KEYS      = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 500000,
  parameter int SHIFT_KEY   = KEY_SHIFT,
  parameter int AUX_ROW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_key_matrix_if.slave     bus,
  input  logic                 flush,
  input  logic                 aux_n,
  output logic                 busy,
  output logic                 overflow,
  output logic                 dropped
);
  localparam int KEY_W   = $clog2(N_KEYS);
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [N_KEYS-1:0] pressed;
  logic [KEY_W-1:0]  rd_addr;
  logic [7:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  key_code_t         code;
  logic              aux_hit;

  assign pop  = (state == S_IDLE) & ~fifo_empty & ~flush;
  // flush wins over a same-cycle byte; the byte is simply lost.
  assign push = bus.rx_valid & ~flush;
  assign code = ascii_to_key(fifo_rdata);
  assign busy = (state != S_IDLE) | ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .wdata (bus.rx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pressed <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (flush) begin
        state   <= S_IDLE;
        cnt     <= '0;
        pressed <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              if (code.valid) begin
                pressed <= (N_KEYS'(1) << code.key)
                         | (code.shift ? (N_KEYS'(1) << SHIFT_KEY) : '0);
                cnt     <= HOLD_LOAD;
                state   <= S_HOLD;
              end else begin
                dropped <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (cnt == '0) begin
              pressed <= '0;
              cnt     <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_GAP: begin
            if (cnt == '0) state <= S_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       overflow <= 1'b0;
    else if (flush)                                  overflow <= 1'b0;
    else if (bus.rx_valid & fifo_full & ~pop)        overflow <= 1'b1;
  end

  assign rd_addr = bus.key_addr;
  // The auxiliary input appears as a held key on every address of one row.
  assign aux_hit = (rd_addr[2:0] == 3'(AUX_ROW)) & ~aux_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           bus.key_out <= 8'hFF;
    else if (bus.key_rd) bus.key_out <= (pressed[rd_addr] | aux_hit) ? 8'hFE : 8'hFF;
  end
endmodule
